// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one restoring divider between NREQ requesters, answering each with q/r/err.
// Define DIV_SHARE_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module div_share_ctrl #(
  parameter int NREQ = 2,
  parameter int W = 16,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_n,
  input  logic [NREQ*W-1:0] req_m,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_done,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_q,
  output logic [W-1:0]      rsp_r,
  output logic              rsp_err,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_n,
  output logic [W-1:0]      div_m,
  input  logic              div_ready,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  state_t r_state, w_next;
  logic [W-1:0] r_n, r_m, r_q, r_r;
  logic r_err;
  logic [IDW-1:0] r_id, w_win;
  logic [W-1:0] w_sel_n, w_sel_m;
  logic w_go;
`ifdef DIV_SHARE_RR_EN
  logic [IDW-1:0] r_last;
  logic w_found;
  always_comb begin
    w_win = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] j;
      j = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_win = j;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_last <= '0;
    else if (w_go) r_last <= w_win;
`else
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[IDW'(k)]) w_win = IDW'(k);
  end
`endif
  // reset gates the ack so no requester sees a grant while the block is held in reset
  assign w_go = reset && (r_state == S_IDLE) && (|req_valid) && div_ready;
  assign w_sel_n = req_n[int'(w_win)*W +: W];
  assign w_sel_m = req_m[int'(w_win)*W +: W];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_go) w_next = (w_sel_m == '0) ? S_RESP : S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!div_ready) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (div_ready) w_next = S_RESP;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_n <= '0;
      r_m <= '0;
      r_id <= '0;
      r_q <= '0;
      r_r <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_n <= w_sel_n;
        r_m <= w_sel_m;
        r_id <= w_win;
        if (w_sel_m == '0) begin
          r_q <= '0;
          r_r <= '0;
          r_err <= 1'b1;
        end
      end
      if (r_state == S_WAIT_DONE && div_ready) begin
        r_q <= div_q;
        r_r <= div_r;
        r_err <= 1'b0;
      end
    end
  end
  assign req_ack   = w_go ? ONE << w_win : '0;
  assign rsp_done  = (r_state == S_RESP) ? ONE << r_id : '0;
  assign rsp_id    = (r_state == S_RESP) ? r_id : '0;
  assign rsp_q     = r_q;
  assign rsp_r     = r_r;
  assign rsp_err   = r_err;
  assign busy      = r_state != S_IDLE;
  assign div_start = r_state == S_ISSUE;
  assign div_n     = busy ? r_n : '0;
  assign div_m     = busy ? r_m : '0;
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: randomized and directed checks of div_share_ctrl against a behavioural scoreboard.
// A simple variable-latency divider model stands in for the shared divider.
module tb_div_share_ctrl;
  localparam int NREQ = 3;
  localparam int W = 16;
  localparam int IDW = $clog2(NREQ);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_n = '0;
  logic [NREQ*W-1:0] req_m = '0;
  logic [NREQ-1:0] req_ack, rsp_done;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_q, rsp_r, div_n, div_m, div_q, div_r;
  logic rsp_err, busy, div_start, div_ready;

  div_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_n(req_n), .req_m(req_m),
    .req_ack(req_ack), .rsp_done(rsp_done), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .busy(busy), .div_start(div_start), .div_n(div_n), .div_m(div_m),
    .div_ready(div_ready), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, ack_cyc = 0, starts = 0, last = 0, ops_done = 0;
  int d_cnt = 0, d_lat = 0, nl = 0, lat_force = -1, keep_cnt = 0;
  int win = 0, cap_id = 0, last_id = 0;
  logic inflight = 1'b0, hold = 1'b0, rnd = 1'b0, scramble = 1'b0, d_busy = 1'b0, due;
  logic [NREQ-1:0] own = '0, ack_seen = '0, exp_ack, exp_done;
  logic [W-1:0] cap_n, cap_m, d_q, d_r, last_q, last_r;
  logic last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int lst);
`ifdef DIV_SHARE_RR_EN
    for (int k = 1; k <= NREQ; k++) if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
    return lst;
  endfunction

  // shared divider: busy for d_lat+1 cycles after accepting a start
  assign div_ready = !d_busy && !hold;
  assign div_q = d_q;
  assign div_r = d_r;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_busy <= 1'b0;
      d_cnt <= 0;
    end else if (d_busy) begin
      if (d_cnt == 0) d_busy <= 1'b0;
      else d_cnt <= d_cnt - 1;
    end else if (div_start) begin
      if (div_m == '0) chk("zero_start", 1, 0);
      d_busy <= 1'b1;
      d_cnt <= nl;
      d_lat <= nl;
      d_q <= (div_m == '0) ? '0 : div_n / div_m;
      d_r <= (div_m == '0) ? '0 : div_n % div_m;
    end
  end

  // scoreboard: one operation in flight; timing from ack is 1 (error) or latency+4
  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      exp_ack = '0;
      win = 0;
      if (!inflight && div_ready && |req_valid) begin
        win = pick(req_valid, last);
        exp_ack[win] = 1'b1;
      end
      chk("ack", req_ack, exp_ack);
      chk("busy", busy, inflight);
      if (inflight) begin
        chk("div_n", div_n, cap_n);
        chk("div_m", div_m, cap_m);
      end
      if (div_start) starts++;
      due = inflight && (cyc == ack_cyc + ((cap_m == '0) ? 1 : d_lat + 4));
      exp_done = '0;
      if (due) exp_done[cap_id] = 1'b1;
      chk("done", rsp_done, exp_done);
      if (due) begin
        chk("rsp_id", rsp_id, cap_id);
        chk("rsp_q", rsp_q, (cap_m == '0) ? 0 : cap_n / cap_m);
        chk("rsp_r", rsp_r, (cap_m == '0) ? 0 : cap_n % cap_m);
        chk("rsp_err", rsp_err, cap_m == '0);
        chk("starts", starts, cap_m != '0);
        last_id = int'(rsp_id);
        last_q = rsp_q;
        last_r = rsp_r;
        last_err = rsp_err;
        own[cap_id] = 1'b0;
        inflight = 1'b0;
        ops_done++;
      end else if (inflight && cyc > ack_cyc + 12) begin
        chk("timeout", 1, 0);
        own = '0;
        inflight = 1'b0;
      end
      if (exp_ack != '0) begin
        inflight = 1'b1;
        cap_id = win;
        cap_n = req_n[win*W +: W];
        cap_m = req_m[win*W +: W];
        ack_cyc = cyc;
        starts = 0;
        last = win;
        own[win] = 1'b1;
        ack_seen[win] = 1'b1;
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] n, input logic [W-1:0] m);
    req_n[i*W +: W] = n;
    req_m[i*W +: W] = m;
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    int s;
    @(posedge clk);
    #1;
    nl = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
    for (int i = 0; i < NREQ; i++) begin
      if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        if (i == 0 && keep_cnt > 0) begin
          keep_cnt--;
          req_n[0 +: W] = W'($urandom);
          req_m[0 +: W] = W'($urandom_range(1, 300));
        end else begin
          req_valid[i] = 1'b0;
          if (scramble) begin
            req_n[i*W +: W] = W'($urandom);
            req_m[i*W +: W] = W'($urandom);
          end
        end
      end
      if (rnd) begin
        if (!req_valid[i] && !own[i] && $urandom_range(0, 3) == 0) begin
          s = int'($urandom_range(0, 7));
          set_req(i, W'($urandom), (s == 0) ? '0 : (s < 4) ? W'($urandom_range(1, 20)) : W'($urandom));
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    hold = rnd && !inflight && ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_ops(input int target, input string tag);
    int k = 0;
    while (ops_done < target && k < 100) begin
      step();
      k++;
    end
    chk(tag, ops_done >= target, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_done"}, rsp_done, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_q"}, rsp_q, 0);
    chk({tag, "_r"}, rsp_r, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, div_start, 0);
    chk({tag, "_divn"}, div_n, 0);
    chk({tag, "_divm"}, div_m, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, f_id;
    logic [W-1:0] f_q, f_r;
    set_req(0, 9, 3);
    set_req(1, 17, 5);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    // contention straight out of reset
    t = ops_done;
    wait_ops(t + 1, "cont1_wait");
    f_id = last_id;
    f_q = last_q;
    f_r = last_r;
    wait_ops(t + 2, "cont2_wait");
`ifdef DIV_SHARE_RR_EN
    chk("cont1_id", f_id, 1); chk("cont1_q", f_q, 3); chk("cont1_r", f_r, 2);
    chk("cont2_id", last_id, 0); chk("cont2_q", last_q, 3); chk("cont2_r", last_r, 0);
`else
    chk("cont1_id", f_id, 0); chk("cont1_q", f_q, 3); chk("cont1_r", f_r, 0);
    chk("cont2_id", last_id, 1); chk("cont2_q", last_q, 3); chk("cont2_r", last_r, 2);
`endif
    set_req(0, 100, 7);
    wait_ops(ops_done + 1, "single_wait");
    chk("single_id", last_id, 0); chk("single_q", last_q, 14);
    chk("single_r", last_r, 2); chk("single_err", last_err, 0);
    set_req(1, 55, 0);
    wait_ops(ops_done + 1, "dz_wait");
    chk("dz_id", last_id, 1); chk("dz_err", last_err, 1);
    chk("dz_q", last_q, 0); chk("dz_r", last_r, 0);
    scramble = 1'b1;
    set_req(2, 1000, 33);
    wait_ops(ops_done + 1, "stab_wait");
    chk("stab_q", last_q, 30); chk("stab_r", last_r, 10);
    scramble = 1'b0;
    t = ops_done;
    keep_cnt = 2;
    set_req(0, 200, 9);
    wait_ops(t + 3, "b2b_wait");
    chk("b2b_ops", ops_done - t, 3);
    rnd = 1'b1;
    repeat (1500) step();
    rnd = 1'b0;
    req_valid = '0;
    k = 0;
    while (inflight && k < 50) begin
      step();
      k++;
    end
    chk("drain", inflight, 0);
    repeat (2) step();
    // abandon an operation while the divider is still working on it
    lat_force = 4;
    set_req(0, 50000, 3);
    k = 0;
    while (!(busy && !div_ready) && k < 30) begin
      step();
      k++;
    end
    step();
    chk("mid_wait_done", {busy, div_ready}, 2'b10);
    reset = 1'b0;
    #1;
    chk_zero("mid_rst");
    inflight = 1'b0;
    own = '0;
    ack_seen = '0;
    last = 0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat_force = -1;
    repeat (4) step();
    set_req(0, 65535, 1);
    wait_ops(ops_done + 1, "post_wait");
    chk("post_q", last_q, 65535); chk("post_r", last_r, 0); chk("post_err", last_err, 0);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
